// File: rtl/dot_acc.sv
// -----------------------------------------------------------------------------
// dot_acc -- dot-product accumulator sitting behind an external pipelined
// 8x8 unsigned multiplier.
//
// A job starts with start/len in IDLE. In RUN the block accepts one operand
// pair per cycle on the op_valid/op_ready handshake. Each accepted pair (an
// "issue") is tracked through an LAT-deep valid shift register that mirrors the
// multiplier pipeline. When the tap bit of that register is set, the product
// on `product` belongs to this job and is added to the accumulator. Issuing
// and accumulating overlap, so back-to-back issues sustain one term per clock.
// After the last issue the FSM waits in DRAIN for the remaining products. It
// then loads `sum` and pulses `done` for one cycle in DONE.
//
// Parameters
//   LAT    multiplier latency in clock edges (operand sample -> product)
//   ACC_W  accumulator / sum width (>= 16)
//   CNT_W  width of len and of the term counters
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   start     in   begin a job (sampled only in IDLE)
//   len       in   number of terms, sampled with start
//   op_valid  in   upstream offers an operand pair to the multiplier
//   op_ready  out  pair accepted this cycle (high only in RUN)
//   product   in   16-bit unsigned multiplier result
//   busy      out  high in every state except IDLE
//   sum       out  final dot product, held until the next accepted start
//   done      out  one-cycle pulse, sum valid
//   ovf       out  sticky carry-out flag for the current job
//
// Configuration
//   DOT_ACC_SAT_EN  defined: an overflowing accumulator saturates to all-ones
//                   for the rest of the job.
//                   Undefined (default): the accumulator wraps modulo 2^ACC_W.
// -----------------------------------------------------------------------------
module dot_acc #(
  parameter int LAT   = 4,
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [15:0]      product,
  output logic             busy,
  output logic [ACC_W-1:0] sum,
  output logic             done,
  output logic             ovf
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] issued_cnt;
  logic [CNT_W-1:0] rcvd_cnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum_q;
  logic             ovf_q;
  logic [LAT-1:0]   vld_sr;

  logic             issue;
  logic             tap;
  logic             accumulate;
  logic [CNT_W-1:0] issued_inc;
  logic [CNT_W-1:0] rcvd_inc;
  logic             last_issue;
  logic             last_rcv;
  logic [ACC_W:0]   add_ext;
  logic             carry;
  logic [ACC_W-1:0] acc_next;
  logic [LAT:0]     vld_shift;

  assign op_ready = (state == S_RUN);
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);
  assign sum      = sum_q;
  assign ovf      = ovf_q;

  assign issue      = op_valid & op_ready;
  assign tap        = vld_sr[LAT-1];
  // Only RUN/DRAIN own in-flight products; by DONE every issue has landed.
  assign accumulate = tap & ((state == S_RUN) | (state == S_DRAIN));
  assign issued_inc = issued_cnt + CNT_W'(1);
  assign rcvd_inc   = rcvd_cnt + CNT_W'(1);
  assign last_issue = issue & (issued_inc == len_q);
  assign last_rcv   = accumulate & (rcvd_inc == len_q);

  // Extra MSB captures the carry out of the accumulator.
  assign add_ext = {1'b0, acc} + (ACC_W + 1)'(product);
  assign carry   = add_ext[ACC_W];

  // Building the shift through a LAT+1 vector keeps LAT=1 legal.
  assign vld_shift = {vld_sr, issue};

  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    acc_next = add_ext[ACC_W-1:0];
`ifdef DOT_ACC_SAT_EN
    // Once saturated, stay pinned at all-ones for the rest of the job.
    if (carry || ovf_q) begin
      acc_next = '1;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      len_q      <= '0;
      issued_cnt <= '0;
      rcvd_cnt   <= '0;
      acc        <= '0;
      sum_q      <= '0;
      ovf_q      <= 1'b0;
      // Clearing the valid register drops any products still in the
      // multiplier pipeline.
      vld_sr     <= '0;
    end else begin
      vld_sr <= vld_shift[LAT-1:0];

      if (accumulate) begin
        acc      <= acc_next;
        rcvd_cnt <= rcvd_inc;
        if (carry) begin
          ovf_q <= 1'b1;
        end
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            len_q      <= len;
            issued_cnt <= '0;
            rcvd_cnt   <= '0;
            acc        <= '0;
            sum_q      <= '0;
            ovf_q      <= 1'b0;
            state      <= (len != '0) ? S_RUN : S_DONE;
          end
        end
        S_RUN: begin
          if (issue) begin
            issued_cnt <= issued_inc;
            if (last_issue) begin
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (last_rcv) begin
            sum_q <= acc_next;
            state <= S_DONE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dot_acc.sv
// -----------------------------------------------------------------------------
// tb_dot_acc -- directed self-checking bench for dot_acc.
// Two instances share stimulus: the default ACC_W=24 build and an ACC_W=16
// build for the overflow case. A small model of the external LAT-stage 8x8
// multiplier feeds `product`. Cycles without an issue carry a junk value, so
// the DUT must rely on its valid pipeline to pick out real products.
// -----------------------------------------------------------------------------
module tb_dot_acc;

  localparam int LAT   = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] len;
  logic             op_valid;
  logic [7:0]       a;
  logic [7:0]       b;
  logic [15:0]      product;

  logic             op_ready, busy, done, ovf;
  logic [23:0]      sum;
  logic             op_ready16, busy16, done16, ovf16;
  logic [15:0]      sum16;

  logic [15:0]      pipe [LAT];

  int passed = 0;
  int total  = 0;
  int cyc;

  always #5 clk = ~clk;

  dot_acc #(.LAT(LAT), .ACC_W(24), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .op_valid(op_valid),
    .op_ready(op_ready), .product(product), .busy(busy), .sum(sum),
    .done(done), .ovf(ovf)
  );

  dot_acc #(.LAT(LAT), .ACC_W(16), .CNT_W(CNT_W)) dut16 (
    .clk(clk), .rst(rst), .start(start), .len(len), .op_valid(op_valid),
    .op_ready(op_ready16), .product(product), .busy(busy16), .sum(sum16),
    .done(done16), .ovf(ovf16)
  );

  // External multiplier model: result of an issue at edge k is on product
  // from edge k+LAT-1, so it is sampled at edge k+LAT. No issue -> junk.
  always @(posedge clk) begin
    pipe[0] <= (op_valid && op_ready) ? 16'(a) * 16'(b) : 16'hBEEF;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign product = pipe[LAT-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic issue(input logic [7:0] x, input logic [7:0] y);
    op_valid = 1'b1;
    a = x;
    b = y;
    tick();
    op_valid = 1'b0;
  endtask

  // Bounded wait for done; returns the number of edges waited.
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; op_valid = 1'b0; a = '0; b = '0;
    repeat (LAT + 1) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", op_ready, 0);
    check("rst_sum", sum, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b0;
    tick();

    // len=3: (2,5),(3,6),(4,7) back to back -> 10+18+28 = 56.
    start = 1'b1; len = 8'd3; tick(); start = 1'b0;
    check("t1_run_ready", op_ready, 1);
    check("t1_run_busy", busy, 1);
    issue(8'd2, 8'd5); issue(8'd3, 8'd6); issue(8'd4, 8'd7);
    check("t1_drain_ready", op_ready, 0);
    wait_done(cyc);
    check("t1_done_seen", done, 1);
    check("t1_latency", cyc, LAT);
    check("t1_sum", sum, 56);
    check("t1_ovf", ovf, 0);
    tick();
    check("t1_done_pulse", done, 0);
    check("t1_idle_busy", busy, 0);
    repeat (3) tick();
    check("t1_sum_hold", sum, 56);

    // len=0: straight to DONE, sum=0, never ready.
    start = 1'b1; len = 8'd0; tick(); start = 1'b0;
    check("t2_done", done, 1);
    check("t2_sum", sum, 0);
    check("t2_ready", op_ready, 0);
    tick();
    check("t2_done_pulse", done, 0);
    check("t2_ready_after", op_ready, 0);

    // len=4, gapped valid 1,0,0,1,1,0,1 of 255*255 -> 4*65025 = 260100.
    // op_valid then stays high in DRAIN; those cycles must not issue.
    start = 1'b1; len = 8'd4; tick(); start = 1'b0;
    issue(8'd255, 8'd255); tick(); tick();
    issue(8'd255, 8'd255); issue(8'd255, 8'd255); tick();
    issue(8'd255, 8'd255);
    op_valid = 1'b1; a = 8'd255; b = 8'd255;
    tick(); tick();
    op_valid = 1'b0;
    wait_done(cyc);
    check("t3_done_seen", done, 1);
    check("t3_sum", sum, 260100);
    check("t3_ovf", ovf, 0);
    tick();

    // len=2, 255*255 twice = 130050: fits 24 bits, overflows 16 bits.
    start = 1'b1; len = 8'd2; tick(); start = 1'b0;
    issue(8'd255, 8'd255); issue(8'd255, 8'd255);
    wait_done(cyc);
    check("t4_done_seen", done, 1);
    check("t4_done16", done16, 1);
    check("t4_sum24", sum, 130050);
    check("t4_ovf24", ovf, 0);
    check("t4_ovf16", ovf16, 1);
`ifdef DOT_ACC_SAT_EN
    check("t4_sum16", sum16, 65535);
`else
    check("t4_sum16", sum16, 64514);
`endif
    tick();
    check("t4_idle16", busy16, 0);

    // Reset two cycles after the 2nd of 3 issues, then len=1 (9,9) -> 81.
    start = 1'b1; len = 8'd3; tick(); start = 1'b0;
    issue(8'd100, 8'd100); issue(8'd100, 8'd100);
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check("t5_rst_busy", busy, 0);
    check("t5_rst_sum", sum, 0);
    start = 1'b1; len = 8'd1; tick(); start = 1'b0;
    issue(8'd9, 8'd9);
    wait_done(cyc);
    check("t5_done_seen", done, 1);
    check("t5_sum", sum, 81);
    check("t5_ovf", ovf, 0);
    tick();

    // len=5 with start (and a new len) asserted mid-run -> 1+4+9+16+25 = 55.
    start = 1'b1; len = 8'd5; tick(); start = 1'b0;
    issue(8'd1, 8'd1); issue(8'd2, 8'd2);
    start = 1'b1; len = 8'd7;
    issue(8'd3, 8'd3); issue(8'd4, 8'd4);
    start = 1'b0;
    issue(8'd5, 8'd5);
    wait_done(cyc);
    check("t6_done_seen", done, 1);
    check("t6_sum", sum, 55);
    tick();
    check("t6_done_pulse", done, 0);
    repeat (3) tick();
    check("t6_no_restart", busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
